idct_2d_inverse: RTL
====================

IDCT_2D_INVERSE -- requirements
Module: idct_2d_inverse

Interface
REQ-001 SHALL have parameter DW, default 16, meaning signed input coefficient width; only 16 is supported.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port in_valid, input, 1 bit: the coefficient row on din0..din3 is valid.
REQ-005 SHALL have port in_ready, output, 1 bit: the block accepts a row; a row is accepted when in_valid and in_ready are both high.
REQ-006 SHALL have ports din0..din3, input, 16 bits each, signed: coefficient row, din0 = lowest frequency.
REQ-007 SHALL have port out_valid, output, 1 bit: dout0..dout3 hold a valid output beat.
REQ-008 SHALL have port out_ready, input, 1 bit: downstream accepts; a beat transfers when out_valid and out_ready are both high.
REQ-009 SHALL have ports dout0..dout3, output, 14 bits each, signed: one reconstructed column, dout0 = row 0.
REQ-010 SHALL have port out_last, output, 1 bit: high on the fourth (final) beat of a block.

Function
REQ-011 SHALL implement the 1-D inverse butterfly for inputs a0..a3: e0=a0+a2, e1=a0-a2, e2=(a1>>>1)-a3, e3=a1+(a3>>>1); outputs y0=e0+e3, y1=e1+e2, y2=e1-e2, y3=e0-e3.
REQ-012 SHALL have a two-state FSM: LOAD (in_ready=1, out_valid=0) and DRAIN (in_ready=0, out_valid=1).
REQ-013 In LOAD, each accepted row SHALL be row-transformed (REQ-011) and stored at 18-bit signed width into buffer row row_cnt, and row_cnt (2 bits) SHALL increment.
REQ-014 Acceptance of the row with row_cnt=3 SHALL move the FSM to DRAIN on that edge and clear row_cnt.
REQ-015 In DRAIN, dout SHALL be driven combinationally from the column transform (REQ-011) of buffer column col_cnt, computed at 20-bit signed width.
REQ-016 Each dout SHALL be the column result rounded as (x+32)>>>6 and truncated to 14 bits.
REQ-017 Each transfer SHALL increment col_cnt; the transfer at col_cnt=3 SHALL clear col_cnt and return the FSM to LOAD.
REQ-018 out_last SHALL equal (state==DRAIN && col_cnt==3).
REQ-019 When out_ready is low, dout, out_last and col_cnt SHALL hold stable.
REQ-020 Latency SHALL be: out_valid rises the cycle after the 4th row is accepted; in_ready rises the cycle after the 4th beat transfers.
REQ-021 In LOAD, in_valid gaps SHALL stall row_cnt with no effect on stored rows.
REQ-022 din SHALL be ignored in DRAIN; out_ready SHALL be ignored in LOAD.

Reset
REQ-023 While rst is high, the FSM SHALL enter LOAD with row_cnt=0 and col_cnt=0, and in_ready SHALL be 0.
REQ-024 After rst is released, outputs SHALL be out_valid=0, out_last=0, dout=0, and in_ready SHALL be 1 from the first cycle after release.
REQ-025 Reset mid-load or mid-drain SHALL discard the partial block; buffer contents need not be cleared.

Configuration
REQ-026 With macro IDCT_OUT_CLIP_EN defined, each rounded dout SHALL be saturated to 0..255 and zero-extended to 14 bits.
REQ-027 With IDCT_OUT_CLIP_EN undefined, dout SHALL be the raw signed rounded value per REQ-016, with no saturation logic present.

Verification
REQ-028 DC case: row0={640,0,0,0}, rows1-3 zero -> 4 beats, all dout=10, out_last high only on beat 4.
REQ-029 Negative DC: row0={-640,0,0,0} -> all dout=-10 without IDCT_OUT_CLIP_EN; all dout=0 with it.
REQ-030 Overflow: row0={20000,0,0,0} -> all dout=313 without IDCT_OUT_CLIP_EN; all dout=255 with it.
REQ-031 Backpressure: hold out_ready=0 for 3 cycles on beat 2 -> dout and out_last stable, no beat lost; in_ready=0 throughout DRAIN.
REQ-032 Gaps: in_valid toggling 1,0,1,0,... over 8 cycles -> 4 rows stored, DRAIN entered after the 4th accepted row.
REQ-033 Reset: assert rst after 2 rows -> out_valid=0; next full block is reconstructed correctly (REQ-028 values).

Source files
------------

// File: rtl/idct_2d_inverse.sv
// 4x4 two-dimensional inverse integer transform.
// Rows arrive one per handshake, are row-transformed and held in an 18-bit buffer. Once all four
// rows are in, the block drains one reconstructed column per output beat, column-transformed at
// 20 bits and rounded by (x + 32) >>> 6.
//
// Optional feature: define IDCT_OUT_CLIP_EN to saturate each output to 0..255 (zero-extended).
//
// Ports:
//   clk                   rising-edge clock
//   rst                   synchronous active-high reset
//   in_valid / in_ready   row handshake; din0..din3 carry one coefficient row (din0 = DC)
//   out_valid / out_ready beat handshake; dout0..dout3 carry one column (dout0 = row 0)
//   out_last              high on the fourth beat of a block
module idct_2d_inverse #(
  parameter int unsigned DW = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] din0,
  input  logic signed [DW-1:0] din1,
  input  logic signed [DW-1:0] din2,
  input  logic signed [DW-1:0] din3,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [13:0]   dout0,
  output logic signed [13:0]   dout1,
  output logic signed [13:0]   dout2,
  output logic signed [13:0]   dout3,
  output logic                 out_last
);

  typedef enum logic {StLoad = 1'b0, StDrain = 1'b1} state_e;

  state_e             r_state;
  state_e             w_state_nxt;
  logic [1:0]         r_row_cnt;
  logic [1:0]         r_col_cnt;
  logic signed [17:0] r_buf [4][4];

  logic               w_row_acc;
  logic               w_col_xfer;
  logic signed [17:0] w_ra [4];
  logic signed [17:0] w_re [4];
  logic signed [17:0] w_ry [4];
  logic signed [19:0] w_ca [4];
  logic signed [19:0] w_ce [4];
  logic signed [19:0] w_cy [4];
  logic signed [13:0] w_q [4];
  logic signed [13:0] w_dout [4];

  // Reset also closes the input side so no row lands in the buffer while rst is high.
  assign in_ready   = (r_state == StLoad) && !rst;
  assign out_valid  = (r_state == StDrain);
  assign out_last   = (r_state == StDrain) && (r_col_cnt == 2'd3);
  assign w_row_acc  = in_valid && in_ready;
  assign w_col_xfer = out_valid && out_ready;

  // Row butterfly at 18 bits: 16-bit inputs grow by at most two bits.
  always_comb begin
    w_ra[0] = {{(18-DW){din0[DW-1]}}, din0};
    w_ra[1] = {{(18-DW){din1[DW-1]}}, din1};
    w_ra[2] = {{(18-DW){din2[DW-1]}}, din2};
    w_ra[3] = {{(18-DW){din3[DW-1]}}, din3};
    w_re[0] = w_ra[0] + w_ra[2];
    w_re[1] = w_ra[0] - w_ra[2];
    w_re[2] = (w_ra[1] >>> 1) - w_ra[3];
    w_re[3] = w_ra[1] + (w_ra[3] >>> 1);
    w_ry[0] = w_re[0] + w_re[3];
    w_ry[1] = w_re[1] + w_re[2];
    w_ry[2] = w_re[1] - w_re[2];
    w_ry[3] = w_re[0] - w_re[3];
  end

  // Column butterfly at 20 bits on buffer column r_col_cnt, then rounding.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      w_ca[k] = {{2{r_buf[k][r_col_cnt][17]}}, r_buf[k][r_col_cnt]};
    end
    w_ce[0] = w_ca[0] + w_ca[2];
    w_ce[1] = w_ca[0] - w_ca[2];
    w_ce[2] = (w_ca[1] >>> 1) - w_ca[3];
    w_ce[3] = w_ca[1] + (w_ca[3] >>> 1);
    w_cy[0] = w_ce[0] + w_ce[3];
    w_cy[1] = w_ce[1] + w_ce[2];
    w_cy[2] = w_ce[1] - w_ce[2];
    w_cy[3] = w_ce[0] - w_ce[3];
    for (int k = 0; k < 4; k++) begin
      // A 20-bit value shifted right by 6 fits exactly in 14 bits.
      w_q[k]    = 14'((w_cy[k] + 20'sd32) >>> 6);
      w_dout[k] = '0;
      if (r_state == StDrain) begin
`ifdef IDCT_OUT_CLIP_EN
        if (w_q[k][13]) begin
          w_dout[k] = '0;
        end else if (|w_q[k][12:8]) begin
          w_dout[k] = 14'sd255;
        end else begin
          w_dout[k] = {6'd0, w_q[k][7:0]};
        end
`else
        w_dout[k] = w_q[k];
`endif
      end
    end
  end

  assign dout0 = w_dout[0];
  assign dout1 = w_dout[1];
  assign dout2 = w_dout[2];
  assign dout3 = w_dout[3];

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StLoad:  if (w_row_acc && (r_row_cnt == 2'd3)) w_state_nxt = StDrain;
      StDrain: if (w_col_xfer && (r_col_cnt == 2'd3)) w_state_nxt = StLoad;
      default: w_state_nxt = StLoad;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= StLoad;
      r_row_cnt <= '0;
      r_col_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      // Both counters wrap 3 -> 0 exactly when the block changes phase.
      if (w_row_acc) r_row_cnt <= r_row_cnt + 2'd1;
      if (w_col_xfer) r_col_cnt <= r_col_cnt + 2'd1;
    end
  end

  // Buffer needs no reset: a discarded partial block is overwritten before it is read.
  always_ff @(posedge clk) begin
    if (w_row_acc) begin
      for (int k = 0; k < 4; k++) begin
        r_buf[r_row_cnt][k] <= w_ry[k];
      end
    end
  end

endmodule
